// File: rtl/sat_pkg.sv
// Shared saturation helpers: clip flag encoding and a width-generic clamp.
package sat_pkg;

  localparam logic [1:0] CLIP_NONE = 2'b00;
  localparam logic [1:0] CLIP_MIN  = 2'b01;
  localparam logic [1:0] CLIP_MAX  = 2'b10;

  // Widest sample any narrowing stage may hand to saturate()
  localparam int SAT_MAXW = 64;

  typedef struct packed {
    logic [SAT_MAXW-1:0] data;  // result in bits [osz-1:0], upper bits zero
    logic [1:0]          clip;  // CLIP_NONE / CLIP_MIN / CLIP_MAX
  } sat_res_t;

  // Clamp the signed isz-bit value in x[isz-1:0] to osz bits (osz < isz).
  // Bits of x above isz-1 are ignored. Loops compare against the constant
  // widths so the function elaborates to plain wiring for fixed isz/osz.
  function automatic sat_res_t saturate(input logic [SAT_MAXW-1:0] x,
                                        input int isz, input int osz);
    sat_res_t res;
    logic     sign_bit;
    logic     any_one;
    logic     all_one;
    sign_bit = 1'b0;
    any_one  = 1'b0;
    all_one  = 1'b1;
    for (int b = 0; b < SAT_MAXW; b++) begin
      if (b == isz - 1) sign_bit = x[b];
      if (b >= osz - 1 && b <= isz - 2) begin
        any_one = any_one | x[b];
        all_one = all_one & x[b];
      end
    end
    res.data = '0;
    res.clip = CLIP_NONE;
    if (!sign_bit && any_one) begin
      res.clip = CLIP_MAX;
      for (int b = 0; b < SAT_MAXW; b++)
        if (b < osz - 1) res.data[b] = 1'b1;
    end else if (sign_bit && !all_one) begin
      res.clip = CLIP_MIN;
      for (int b = 0; b < SAT_MAXW; b++)
        if (b == osz - 1) res.data[b] = 1'b1;
    end else begin
      for (int b = 0; b < SAT_MAXW; b++)
        if (b < osz) res.data[b] = x[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_picker #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic           gnt_valid,
  output logic [CHW-1:0] gnt_idx
);

  logic [2*NCH-1:0] req_dbl;
  logic [NCH-1:0]   req_rot;
  logic [CHW-1:0]   cand_idx [NCH];

  // Rotate requests so bit k means "channel ptr+k"
  assign req_dbl = {req, req};
  assign req_rot = NCH'(req_dbl >> ptr);

  // Absolute channel number for each rotated position, modulo NCH
  for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
    logic [CHW:0] sum;
    assign sum = {1'b0, ptr} + (CHW+1)'(gi);
    assign cand_idx[gi] = (sum >= (CHW+1)'(NCH)) ? CHW'(sum - (CHW+1)'(NCH))
                                                  : sum[CHW-1:0];
  end

  // Lowest rotated position wins; scan downward so it is assigned last
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/sat_arbiter.sv
// Round-robin share of one saturation stage among NCH channels, with a
// registered tagged output stage and per-channel saturating clip counters.
module sat_arbiter
  import sat_pkg::*;
#(
  parameter  int NCH  = 4,
  parameter  int ISZ  = 17,
  parameter  int OSZ  = 12,
  parameter  int CNTW = 16,
  localparam int CHW  = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH*ISZ-1:0] in_data,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  output logic [OSZ-1:0]     out_data,
  output logic [CHW-1:0]     out_chan,
  output logic [1:0]         out_clip,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [CHW-1:0]     cnt_sel,
  input  logic               cnt_clr,
  output logic [CNTW-1:0]    clip_cnt
);

  logic [OSZ-1:0]  out_data_reg;
  logic [CHW-1:0]  out_chan_reg;
  logic [1:0]      out_clip_reg;
  logic            out_valid_reg;
  logic [CHW-1:0]  ptr_reg;
  logic [CHW-1:0]  ptr_next;
  logic            advance;
  logic            accept;
  logic            gnt_valid;
  logic [CHW-1:0]  gnt_idx;
  logic [ISZ-1:0]  ch_sample [NCH];
  logic [ISZ-1:0]  gnt_sample;
  sat_res_t        sat_res;
  logic            sat_clipped;
  logic [CNTW-1:0] cnt_arr [NCH];
  logic            unused_sat_bits;

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_clip  = out_clip_reg;
  assign out_valid = out_valid_reg;

  // Output stage can take a new sample when empty or being drained
  assign advance = ~out_valid_reg | out_ready;

  rr_picker #(.NCH(NCH), .CHW(CHW)) u_picker (
    .req       (in_valid),
    .ptr       (ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Gating with reset keeps every in_ready low while reset is held
  assign accept = advance & gnt_valid & reset;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign ch_sample[gi] = in_data[gi*ISZ +: ISZ];
    assign in_ready[gi]  = accept & (gnt_idx == CHW'(gi));
  end

  assign gnt_sample      = ch_sample[gnt_idx];
  assign sat_res         = saturate(SAT_MAXW'(gnt_sample), ISZ, OSZ);
  assign sat_clipped     = (sat_res.clip != CLIP_NONE);
  assign unused_sat_bits = ^sat_res.data[SAT_MAXW-1:OSZ];

  // Next search starts just after the channel granted this cycle
  assign ptr_next = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

  // Output register stage and RR pointer: load on accept, empty on idle, hold on stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_clip_reg  <= CLIP_NONE;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else if (accept) begin
      out_data_reg  <= sat_res.data[OSZ-1:0];
      out_chan_reg  <= gnt_idx;
      out_clip_reg  <= sat_res.clip;
      out_valid_reg <= 1'b1;
      ptr_reg       <= ptr_next;
    end else if (advance) begin
      out_valid_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
    logic [CNTW-1:0] cnt_reg;
    logic            inc_hit;
    logic            clr_hit;
    assign inc_hit     = accept & sat_clipped & (gnt_idx == CHW'(gi));
    assign clr_hit     = cnt_clr & (cnt_sel == CHW'(gi));
    assign cnt_arr[gi] = cnt_reg;

    // Saturating clip counter; a clear in the same cycle as a clip leaves 1
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_reg <= '0;
      end else if (clr_hit) begin
        cnt_reg <= inc_hit ? CNTW'(1) : '0;
      end else if (inc_hit && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Present the selected channel's counter
  always_comb begin
    clip_cnt = '0;
    for (int i = 0; i < NCH; i++)
      if (cnt_sel == CHW'(i)) clip_cnt = cnt_arr[i];
  end

endmodule

// File: tb/tb_sat_arbiter.sv
// Scoreboard bench for sat_arbiter: reference model pushes expected outputs,
// monitor pops and compares whenever the DUT presents a sample.
module tb_sat_arbiter;

  localparam int NCH  = 4;
  localparam int ISZ  = 17;
  localparam int OSZ  = 12;
  localparam int CNTW = 16;
  localparam int CHW  = 2;
  localparam longint CMAX = (longint'(1) << CNTW) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NCH*ISZ-1:0] in_data = '0;
  logic [NCH-1:0]     in_valid = '0;
  logic [NCH-1:0]     in_ready;
  logic [OSZ-1:0]     out_data;
  logic [CHW-1:0]     out_chan;
  logic [1:0]         out_clip;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [CHW-1:0]     cnt_sel = '0;
  logic               cnt_clr = 1'b0;
  logic [CNTW-1:0]    clip_cnt;

  always #5 clk = ~clk;

  sat_arbiter #(.NCH(NCH), .ISZ(ISZ), .OSZ(OSZ), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_chan(out_chan),
    .out_clip(out_clip), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .clip_cnt(clip_cnt)
  );

  typedef struct {
    logic [OSZ-1:0] data;
    int             chan;
    logic [1:0]     clip;
  } exp_t;

  exp_t           q[$];
  int             n_chk = 0;
  int             n_fail = 0;
  bit             verbose = 1'b1;
  bit             log_en = 1'b0;
  int             chan_log[$];
  logic [NCH-1:0] acc_s = '0;
  int             m_ptr = 0;
  bit             m_valid = 1'b0;
  longint         m_cnt[NCH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference clamp by signed value range
  function automatic exp_t ref_sat(input logic [ISZ-1:0] x, input int ch);
    exp_t   r;
    longint v, hi, lo;
    v  = longint'($signed(x));
    hi = (longint'(1) << (OSZ - 1)) - 1;
    lo = -(longint'(1) << (OSZ - 1));
    r.chan = ch;
    if (v > hi) begin
      r.data = OSZ'(hi); r.clip = 2'b10;
    end else if (v < lo) begin
      r.data = OSZ'(lo); r.clip = 2'b01;
    end else begin
      r.data = OSZ'(v);  r.clip = 2'b00;
    end
    return r;
  endfunction

  function automatic logic [ISZ-1:0] rand_sample();
    logic [ISZ-1:0] r;
    logic [ISZ-1:0] edges [4];
    edges[0] = 17'h007FF; edges[1] = 17'h00800;
    edges[2] = 17'h1F800; edges[3] = 17'h1F7FF;
    r = ISZ'($urandom);
    case ($urandom_range(3))
      0: r = {{(ISZ-OSZ){r[OSZ-1]}}, r[OSZ-1:0]};
      1: r = edges[$urandom_range(3)];
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: compare presented output with head of scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_outputs", {out_valid, out_clip, out_chan, out_data}, 0);
    end else begin
      chk("out_valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        exp_t e;
        e = q[0];
        chk("out_data", out_data, e.data);
        chk("out_chan", out_chan, e.chan);
        chk("out_clip", out_clip, e.clip);
        if (out_ready) begin
          if (verbose)
            $display("xfer t=%0t chan=%0d data=%h clip=%b", $time, out_chan, out_data, out_clip);
          if (log_en) chan_log.push_back(int'(out_chan));
          void'(q.pop_front());
        end
      end
    end
  end

  // Reference model: grant, expected in_ready, scoreboard push, counters
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      chk("reset_in_ready", in_ready, 0);
      m_ptr = 0;
      m_valid = 1'b0;
      q.delete();
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      acc_s = '0;
    end else begin
      int             g;
      int             inc_ch;
      bit             adv;
      logic [NCH-1:0] exp_rdy;
      chk("clip_cnt", clip_cnt, m_cnt[cnt_sel]);
      adv = !m_valid || out_ready;
      g = -1;
      for (int k = 0; k < NCH; k++)
        if (g < 0 && in_valid[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
      exp_rdy = '0;
      if (adv && g >= 0) exp_rdy[g] = 1'b1;
      chk("in_ready", in_ready, exp_rdy);
      acc_s = in_ready;
      inc_ch = -1;
      if (adv && g >= 0) begin
        exp_t e;
        e = ref_sat(in_data[g*ISZ +: ISZ], g);
        q.push_back(e);
        m_valid = 1'b1;
        m_ptr = (g + 1) % NCH;
        if (e.clip != 2'b00) inc_ch = g;
      end else if (adv) begin
        m_valid = 1'b0;
      end
      if (cnt_clr) m_cnt[cnt_sel] = 0;
      if (inc_ch >= 0 && m_cnt[inc_ch] < CMAX) m_cnt[inc_ch]++;
    end
  end

  task automatic put(input int ch, input logic [ISZ-1:0] d);
    in_valid[ch] = 1'b1;
    in_data[ch*ISZ +: ISZ] = d;
  endtask

  // Advance one clock; drop valids the DUT accepted at that edge
  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = in_valid & ~acc_s;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (in_valid == '0 && q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_timeout", done, 1'b1);
  endtask

  task automatic quiet_reset();
    reset = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Pass-through sample on ch1, one-cycle latency
    cnt_sel = 1;
    put(1, 17'h00400);
    tick();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 12'h400);
    chk("t1_chan", out_chan, 1);
    chk("t1_cnt1", clip_cnt, 0);
    drain();

    // Positive then negative clamp
    put(0, 17'h0F000);
    tick();
    put(2, 17'h1F000);
    tick();
    drain();
    cnt_sel = 0; #1 chk("t2_cnt0", clip_cnt, 1);
    cnt_sel = 2; #1 chk("t2_cnt2", clip_cnt, 1);

    // Reset mid-stream while holding a sample
    cnt_sel = 0;
    put(0, 17'h0F000);
    tick();
    chk("t6_valid_before", out_valid, 1'b1);
    #1 reset = 1'b0;
    #1 chk("t6_valid_async", out_valid, 1'b0);
    chk("t6_cnt_async", clip_cnt, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    put(2, rand_sample());
    put(1, rand_sample());
    #1 chk("t6_first_grant", in_ready, 4'b0010);
    tick();
    chk("t6_first_chan", out_chan, 1);
    drain();

    // Back-to-back rotation with all channels busy
    quiet_reset();
    chan_log.delete();
    log_en = 1'b1;
    repeat (8) begin
      for (int ch = 0; ch < NCH; ch++)
        if (!in_valid[ch]) put(ch, rand_sample());
      tick();
    end
    drain();
    log_en = 1'b0;
    chk("t3_log_len", chan_log.size(), 11);
    for (int i = 0; i < chan_log.size() && i < 8; i++)
      chk("t3_rotation", chan_log[i], i % NCH);

    // Stall: ch3 must wait until the output drains
    out_ready = 1'b0;
    put(2, rand_sample());
    tick();
    put(3, rand_sample());
    repeat (3) begin
      tick();
      chk("t4_rdy3_stalled", in_ready[3], 1'b0);
      chk("t4_out_held", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    drain();

    // Counter saturation and clear-with-increment
    verbose = 1'b0;
    cnt_sel = 0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    repeat (int'(CMAX) - 1) begin
      put(0, 17'h0F000);
      tick();
    end
    drain();
    chk("t5_cnt_preload", clip_cnt, CMAX - 1);
    repeat (2) begin
      put(0, 17'h10000);
      tick();
    end
    drain();
    chk("t5_cnt_sat", clip_cnt, CMAX);
    put(0, 17'h0F000);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    drain();
    chk("t5_clr_inc", clip_cnt, 1);
    verbose = 1'b1;

    // Randomized traffic, backpressure and clears
    repeat (3000) begin
      out_ready = ($urandom_range(3) != 0);
      cnt_sel   = CHW'($urandom_range(NCH - 1));
      cnt_clr   = ($urandom_range(19) == 0);
      for (int ch = 0; ch < NCH; ch++)
        if (!in_valid[ch] && $urandom_range(2) == 0) put(ch, rand_sample());
      tick();
    end
    drain();
    chk("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sat_arbiter.md
# sat_arbiter

Round-robin scheduler that shares a single saturation stage among NCH receive channels. It accepts wide signed samples from each channel over valid/ready handshakes and clamps each granted sample to OSZ bits. The output is a single tagged stream. It also keeps per-channel saturating clip counters for AGC/overload monitoring. It sits between the per-channel decimation/gain stages and the narrow sample packer feeding the host interface.

## Interface
- NCH, 4, number of requesting channels (2..8)
- ISZ, 17, input sample width, signed
- OSZ, 12, output sample width, signed, OSZ < ISZ
- CNTW, 16, clip counter width
- CHW, $clog2(NCH), channel index width (derived)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset; low = in reset
- in_data  in  NCH*ISZ  channel i sample at [i*ISZ +: ISZ]
- in_valid  in  NCH  per-channel sample valid
- in_ready  out  NCH  per-channel accept, at most one bit high
- out_data  out  OSZ  saturated sample
- out_chan  out  CHW  source channel of out_data
- out_clip  out  2  {max, min}: 2'b10 clamped positive, 2'b01 clamped negative, 2'b00 pass-through
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accept
- cnt_sel  in  CHW  channel whose clip counter is presented
- cnt_clr  in  1  single-cycle clear of counter cnt_sel
- clip_cnt  out  CNTW  clip count of channel cnt_sel, combinational mux of registers

## Operation
- Reset (reset low): out_valid=0, out_data=0, out_chan=0, out_clip=0, all counters 0, RR pointer=0. in_ready is 0 while reset is low.
- advance = ~out_valid | out_ready.
- Arbitration: the grant goes to the first channel with in_valid high, searching from pointer to pointer+NCH-1 modulo NCH.
  - in_ready[g] = advance & in_valid[g]. All other in_ready bits are 0.
  - in_ready depends combinationally on in_valid; requesters must not make in_valid depend on in_ready.
- Accept (any in_ready high):
  - Register the saturated sample, g, and the clip flags into the output stage.
  - Set out_valid=1.
  - Pointer ← (g+1) mod NCH.
- No accept while advance=1: out_valid ← 0 and the pointer holds.
- advance=0: the output stage and pointer hold. out_data, out_chan and out_clip stay stable while out_valid & ~out_ready.
- Saturation, with x = in sample:
  - max = ~x[ISZ-1] & |x[ISZ-2:OSZ-1] → out = 0 followed by OSZ-1 ones.
  - min = x[ISZ-1] & ~&x[ISZ-2:OSZ-1] → out = 1 followed by OSZ-1 zeros.
  - Otherwise out = x[OSZ-1:0].
- Counters: on accept with max|min, counter[g] increments and saturates at 2^CNTW-1.
  - Clear of a channel not being incremented → 0.
  - Clear and increment on the same channel in the same cycle → 1.
  - Clear and increment on different channels both take effect.

## Timing
- Latency: accept in cycle N → out_valid with the sample in cycle N+1.
- Throughput: one sample per cycle with out_ready held high.
- Back-to-back: with all in_valid high and out_ready high, grants rotate 0,1,…,NCH-1,0 on consecutive cycles.
- Fairness: a continuously valid channel is granted within NCH accepts.
- clip_cnt reflects a clear or increment from cycle N starting in cycle N+1.
- Reset asserted mid-stream: outputs go to reset values immediately, and any in-flight sample is dropped. After reset deasserts, arbitration starts from channel 0.

## Structure
- Shared package sat_pkg holds the clip flag encoding constants (CLIP_NONE=2'b00, CLIP_MIN=2'b01, CLIP_MAX=2'b10) and a saturate function of (ISZ, OSZ). The function is reused by other narrowing stages.
- One sub-module, rr_picker: combinational, with inputs req[NCH] and ptr[CHW] and outputs gnt_valid and gnt_idx[CHW]. It is verified standalone.
- The top level holds the output register stage, the pointer register and the counter array.

## Test plan
- Reset, then ch1 valid with 17'sh00400: accepted in cycle N. In N+1, out_data=12'sh400, out_chan=1, out_clip=00, and counter1 stays 0.
- ch0 17'sh0F000, then ch2 17'sh1F000 (−4096): outputs 12'h7FF with clip 10, then 12'h800 with clip 01. Counters 0 and 2 each read 1.
- All four channels valid continuously, out_ready=1 for 8 cycles: out_chan sequence 0,1,2,3,0,1,2,3, with exactly one in_ready high per cycle.
- out_ready low for 3 cycles while ch3 is held valid: output stays stable, and in_ready[3] stays 0 until one cycle with out_ready=1. Nothing is lost or duplicated.
- Counter edges: preload counter0 to 2^CNTW−2 via clipping samples and clip twice → reads 0xFFFF. Then cnt_clr coincident with a clip on ch0 → reads 1.
- Assert reset for one cycle while out_valid=1: out_valid=0 immediately and counters=0. The first grant after release goes to the lowest valid channel.
